aes128_decrypt_iter: RTL



---
 rtl/aes_pkg.sv | 99 +++++++++
 rtl/aes_sbox.sv | 56 +++++
 rtl/aes128_decrypt_iter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) / row-shuffle helpers for the AES-128 cores.
package aes_pkg;

    localparam int NB = 4;
    localparam int NK = 4;
    localparam int NR = 10;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } fsm_t;

    function automatic byte_t get_rcon(input logic [3:0] idx);
        byte_t rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Byte i sits at row i%4, column i/4, most significant byte first.
    function automatic byte_t get_byte(input state_t s, input int idx);
        return s[127-8*idx -: 8];
    endfunction

    function automatic byte_t gf_mul2(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul09(input byte_t b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ b;
    endfunction

    function automatic byte_t gf_mul0b(input byte_t b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(b) ^ b;
    endfunction

    function automatic byte_t gf_mul0d(input byte_t b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ b;
    endfunction

    function automatic byte_t gf_mul0e(input byte_t b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ gf_mul2(b);
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < NB; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = get_byte(s, 4*((c+r)%4) + r);
        return o;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < NB; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = get_byte(s, 4*((c-r+4)%4) + r);
        return o;
    endfunction

    function automatic word_t inv_mix_col(input word_t a);
        byte_t a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3),
                gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3),
                gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3),
                gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3)};
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) wrapped by the affine map,
// inverse selects the inverse S-box.
module aes_sbox
    import aes_pkg::*;
(
    input  logic  inverse,
    input  byte_t din,
    output byte_t dout
);

    function automatic byte_t rotl8(input byte_t b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_mul2(x);
        end
        return p;
    endfunction

    // a^254 is the inverse for nonzero a and maps 0 to 0, as AES requires.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    byte_t pre_s;
    byte_t inv_s;

    // Inverse affine before inversion for the inverse box, forward affine after it otherwise
    always_comb begin
        if (inverse) begin
            pre_s = rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05;
        end else begin
            pre_s = din;
        end
        inv_s = gf_inv(pre_s);
        if (inverse) begin
            dout = inv_s;
        end else begin
            dout = inv_s ^ rotl8(inv_s, 1) ^ rotl8(inv_s, 2) ^ rotl8(inv_s, 3)
                 ^ rotl8(inv_s, 4) ^ 8'h63;
        end
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption: forward key expansion to rk10, then one inverse round per clock.
// Optional macro AES_DEC_KEYCACHE_EN caches the last key's rk10 so a repeated key skips expansion.
module aes128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] Block,
    input  logic [127:0] Key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] Result
);

    if (NUM_ROUNDS != NR) begin : g_bad_rounds
        $error("aes128_decrypt_iter supports only NUM_ROUNDS = 10");
    end

    fsm_t       fsm_r;
    logic [3:0] cnt_r;
    state_t     state_r;
    state_t     key_r;

    state_t isr_s, isb_s, ark_s, imc_s;
    word_t  w0_s, w1_s, w2_s, w3_s;
    word_t  sub_in_s, rot_s, sub_out_s, rcon_word_s, fwd_w0_s;
    state_t key_fwd_s, key_inv_s, hit_rk_s;
    logic   hit_s, accept_s;

    assign isr_s    = inv_shift_rows(state_r);
    assign ark_s    = isb_s ^ key_r;
    assign imc_s    = inv_mix_columns(ark_s);
    assign accept_s = in_valid && in_ready;

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_sbox u_sbox (
            .inverse (1'b1),
            .din     (isr_s[127-8*i -: 8]),
            .dout    (isb_s[127-8*i -: 8])
        );
    end

    for (genvar i = 0; i < 4; i++) begin : g_fwd_sbox
        aes_sbox u_sbox (
            .inverse (1'b0),
            .din     (rot_s[31-8*i -: 8]),
            .dout    (sub_out_s[31-8*i -: 8])
        );
    end

    // SubWord input: last word going forward, the already-unwound w3' going backward
    always_comb begin
        w0_s = key_r[127:96];
        w1_s = key_r[95:64];
        w2_s = key_r[63:32];
        w3_s = key_r[31:0];
        if (fsm_r == ST_KEYEXP) begin
            sub_in_s = w3_s;
        end else begin
            sub_in_s = w3_s ^ w2_s;
        end
        rot_s = {sub_in_s[23:0], sub_in_s[31:24]};
    end

    // One forward and one inverse key-schedule step; counter doubles as the Rcon index
    always_comb begin
        rcon_word_s = {get_rcon(cnt_r), 24'h000000};
        fwd_w0_s    = w0_s ^ sub_out_s ^ rcon_word_s;
        key_fwd_s   = {fwd_w0_s,
                       w1_s ^ fwd_w0_s,
                       w2_s ^ w1_s ^ fwd_w0_s,
                       w3_s ^ w2_s ^ w1_s ^ fwd_w0_s};
        key_inv_s   = {w0_s ^ sub_out_s ^ rcon_word_s,
                       w1_s ^ w0_s,
                       w2_s ^ w1_s,
                       w3_s ^ w2_s};
    end

`ifdef AES_DEC_KEYCACHE_EN
    logic   cache_valid_r;
    state_t cache_key_r;
    state_t cache_rk10_r;

    assign hit_s    = cache_valid_r && (Key == cache_key_r);
    assign hit_rk_s = cache_rk10_r;

    // Invalidate on a miss, fill once expansion of that key has finished
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_r <= 1'b0;
            cache_key_r   <= '0;
            cache_rk10_r  <= '0;
        end else if ((fsm_r == ST_IDLE) && accept_s && !hit_s) begin
            cache_valid_r <= 1'b0;
            cache_key_r   <= Key;
        end else if ((fsm_r == ST_KEYEXP) && (cnt_r == 4'd9)) begin
            cache_valid_r <= 1'b1;
            cache_rk10_r  <= key_fwd_s;
        end
    end
`else
    assign hit_s    = 1'b0;
    assign hit_rk_s = Key;
`endif

    // Control FSM with registered handshake outputs and the round datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r     <= ST_IDLE;
            cnt_r     <= 4'd0;
            state_r   <= '0;
            key_r     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Result    <= '0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r  <= Block;
                        in_ready <= 1'b0;
                        if (hit_s) begin
                            key_r <= hit_rk_s;
                            cnt_r <= 4'd9;
                            fsm_r <= ST_INIT;
                        end else begin
                            key_r <= Key;
                            cnt_r <= 4'd0;
                            fsm_r <= ST_KEYEXP;
                        end
                    end
                end
                ST_KEYEXP: begin
                    key_r <= key_fwd_s;
                    if (cnt_r == 4'd9) begin
                        fsm_r <= ST_INIT;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_INIT: begin
                    state_r <= state_r ^ key_r;
                    key_r   <= key_inv_s;
                    cnt_r   <= 4'd8;
                    fsm_r   <= ST_ROUND;
                end
                ST_ROUND: begin
                    state_r <= imc_s;
                    key_r   <= key_inv_s;
                    if (cnt_r == 4'd0) begin
                        fsm_r <= ST_FINAL;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_FINAL: begin
                    Result    <= ark_s;
                    out_valid <= 1'b1;
                    fsm_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm_r     <= ST_IDLE;
                    end
                end
                default: begin
                    fsm_r     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
